// File: rtl/mem_access_pkg.sv
// Shared widths, funct3 codes and FSM state encoding for the MEM stage.
package mem_access_pkg;

    localparam int ADDR_LEN     = 32;
    localparam int REG_LEN      = 32;
    localparam int REG_ADDR_LEN = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [REG_LEN-1:0] ZERO_WORD = '0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Index of the final byte of an access: 0 for byte, 1 for half, 3 for word.
    function automatic logic [1:0] last_byte_idx(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load word by access size.
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [REG_LEN-1:0] bytes_i,
    input  logic [2:0]         funct3_i,
    output logic [REG_LEN-1:0] data_o
);

    logic sign_fill;

    always_comb begin
        data_o    = ZERO_WORD;
        sign_fill = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                sign_fill = ~funct3_i[2] & bytes_i[7];
                data_o    = {{(REG_LEN-8){sign_fill}}, bytes_i[7:0]};
            end
            2'b01: begin
                sign_fill = ~funct3_i[2] & bytes_i[15];
                data_o    = {{(REG_LEN-16){sign_fill}}, bytes_i[15:0]};
            end
            default: data_o = bytes_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: byte-serial load/store engine over an 8-bit req/ack port, stalling the pipe while busy.
// Memory port: mem_req_o stays high until mem_ack_i; address/data hold until the ack edge.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    load_enable_i,
    input  logic                    store_enable_i,
    input  logic [ADDR_LEN-1:0]     load_store_addr_i,
    input  logic [2:0]              funct3_i,
    input  logic [REG_LEN-1:0]      store_data_i,
    input  logic [REG_LEN-1:0]      rd_data_i,
    input  logic [REG_ADDR_LEN-1:0] rd_addr_i,
    input  logic                    rd_write_enable_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_LEN-1:0]     mem_addr_o,
    output logic [7:0]              mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [7:0]              mem_rdata_i,
    output logic [REG_LEN-1:0]      rd_data_o,
    output logic [REG_ADDR_LEN-1:0] rd_addr_o,
    output logic                    rd_write_enable_o,
    output logic                    stall_req_o,
    output logic [1:0]              state_dbg_o
);

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [ADDR_LEN-1:0]     addr_q, addr_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [REG_LEN-1:0]      sdata_q, sdata_d;
    logic [REG_LEN-1:0]      bytes_q, bytes_d;
    logic [REG_ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
    logic                    rd_we_q, rd_we_d;
    logic                    is_store_q, is_store_d;
    logic                    mem_op;
    logic [REG_LEN-1:0]      load_word;

    assign mem_op      = load_enable_i | store_enable_i;
    assign state_dbg_o = state_q;

    mem_load_ext u_ext (
        .bytes_i  (bytes_q),
        .funct3_i (funct3_q),
        .data_o   (load_word)
    );

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        addr_d            = addr_q;
        funct3_d          = funct3_q;
        sdata_d           = sdata_q;
        bytes_d           = bytes_q;
        rd_addr_d         = rd_addr_q;
        rd_we_d           = rd_we_q;
        is_store_d        = is_store_q;
        mem_req_o         = DISABLE;
        mem_we_o          = DISABLE;
        mem_addr_o        = '0;
        mem_wdata_o       = 8'h00;
        rd_data_o         = ZERO_WORD;
        rd_addr_o         = '0;
        rd_write_enable_o = DISABLE;
        stall_req_o       = DISABLE;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    stall_req_o = ENABLE;
                    addr_d      = load_store_addr_i;
                    funct3_d    = funct3_i;
                    sdata_d     = store_data_i;
                    rd_addr_d   = rd_addr_i;
                    rd_we_d     = rd_write_enable_i;
                    is_store_d  = store_enable_i;
                    cnt_d       = 2'd0;
                    bytes_d     = ZERO_WORD;
                    state_d     = ST_ACCESS;
                end else begin
                    rd_data_o         = rd_data_i;
                    rd_addr_o         = rd_addr_i;
                    rd_write_enable_o = rd_write_enable_i;
                end
            end
            ST_ACCESS: begin
                stall_req_o = ENABLE;
                mem_req_o   = ENABLE;
                mem_we_o    = is_store_q;
                mem_addr_o  = addr_q + ADDR_LEN'(cnt_q);
                mem_wdata_o = sdata_q[{cnt_q, 3'b000} +: 8];
                if (mem_ack_i) begin
                    if (!is_store_q) begin
                        bytes_d[{cnt_q, 3'b000} +: 8] = mem_rdata_i;
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last_byte_idx(funct3_q)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Pipeline advances on this edge; inputs now belong to the next instruction.
                state_d = ST_IDLE;
                if (!is_store_q) begin
                    rd_data_o         = load_word;
                    rd_addr_o         = rd_addr_q;
                    rd_write_enable_o = rd_we_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst_in) begin
            rd_write_enable_o = DISABLE;
            stall_req_o       = DISABLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= '0;
            funct3_q   <= 3'b000;
            sdata_q    <= ZERO_WORD;
            bytes_q    <= ZERO_WORD;
            rd_addr_q  <= '0;
            rd_we_q    <= DISABLE;
            is_store_q <= DISABLE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            funct3_q   <= funct3_d;
            sdata_q    <= sdata_d;
            bytes_q    <= bytes_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            is_store_q <= is_store_d;
        end
    end

endmodule
